// File: rtl/img_pkg.sv
// Shared image geometry, bus widths and FSM encodings for the UART image loader.
package img_pkg;

    localparam int H_IMAGE_PIXEL = 100;
    localparam int V_IMAGE_PIXEL = 100;
    localparam int IMG_PIXELS    = H_IMAGE_PIXEL * V_IMAGE_PIXEL;
    localparam int AddressWidth  = 14;
    localparam int DataWidth     = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK
    } load_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/img_uart_loader_if.sv
// Image RAM write port: the loader is the master, the RAM side the slave.
interface img_uart_loader_if #(
    parameter int AddressWidth = img_pkg::AddressWidth,
    parameter int DataWidth    = img_pkg::DataWidth
);
    logic                    wr_en;
    logic [AddressWidth-1:0] wr_addr;
    logic [DataWidth-1:0]    wr_data;

    modport master (output wr_en, output wr_addr, output wr_data);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver on an already-synchronised rx line; centre-samples every bit.
module uart_byte_rx #(
    parameter int clk_freq = 12000000,
    parameter int baud     = 115200
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       ferr
);
    import img_pkg::*;

    localparam int DIV  = clk_freq / baud;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV) + 1;

    rx_state_t   state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0]  bit_idx, bit_next;
    logic [7:0]  shift, shift_next;
    logic        rx_prev;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state   <= RX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            rx_prev <= 1'b1;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_next;
            shift   <= shift_next;
            rx_prev <= rx;
        end
    end

    // byte_valid/ferr are combinational on the stop sample so the write lands one cycle later
    always_comb begin
        state_next = state;
        cnt_next   = cnt + CW'(1);
        bit_next   = bit_idx;
        shift_next = shift;
        byte_valid = 1'b0;
        ferr       = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_next = '0;
                if (rx_prev && !rx) state_next = RX_START;
            end
            RX_START: begin
                if (cnt == CW'(HALF - 1)) begin
                    cnt_next   = '0;
                    bit_next   = '0;
                    state_next = rx ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == CW'(DIV - 1)) begin
                    cnt_next   = '0;
                    shift_next = {rx, shift[7:1]};
                    bit_next   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt == CW'(DIV - 1)) begin
                    cnt_next   = '0;
                    state_next = RX_IDLE;
                    byte_valid = rx;
                    ferr       = !rx;
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

    assign rx_byte = shift;

endmodule

// File: rtl/img_uart_loader.sv
// Streams a UART image into the image RAM in raster order, with partial-frame timeout.
// Optional IMG_LOADER_CHECKSUM_EN: a trailing XOR checksum byte validates each frame.
module img_uart_loader #(
    parameter int clk_freq     = 12000000,
    parameter int baud         = 115200,
    parameter int AddressWidth = img_pkg::AddressWidth,
    parameter int DataWidth    = img_pkg::DataWidth,
    parameter int IMG_PIXELS   = img_pkg::IMG_PIXELS,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              rx,
    img_uart_loader_if.master wr,
    output logic              loading,
    output logic              frame_done,
    output logic              err
);
    import img_pkg::*;

    localparam int DIV    = clk_freq / baud;
    localparam int TLIMIT = TIMEOUT_BITS * DIV;
    localparam int TW     = $clog2(TLIMIT) + 1;
    localparam logic [AddressWidth-1:0] LAST_ADDR = AddressWidth'(IMG_PIXELS - 1);

    logic rx_meta, rx_sync;
    logic [7:0] rx_byte;
    logic byte_valid, ferr;

    load_state_t state, state_next;
    logic [AddressWidth-1:0] addr, addr_next;
    logic [TW-1:0] tcnt;
    logic timeout, do_write, done_next, err_next, loading_next;
`ifdef IMG_LOADER_CHECKSUM_EN
    logic [7:0] acc, acc_next;
`endif

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    uart_byte_rx #(.clk_freq(clk_freq), .baud(baud)) u_rx (
        .clk_in     (clk_in),
        .reset      (reset),
        .rx         (rx_sync),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .ferr       (ferr)
    );

    // Idle-time counter only runs while a frame is open; any accepted byte restarts it
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset)                            tcnt <= '0;
        else if (state == ST_IDLE || byte_valid) tcnt <= '0;
        else                                   tcnt <= tcnt + TW'(1);
    end
    assign timeout = (tcnt == TW'(TLIMIT - 1));

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            addr       <= '0;
            loading    <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            wr.wr_en   <= 1'b0;
            wr.wr_addr <= '0;
            wr.wr_data <= '0;
`ifdef IMG_LOADER_CHECKSUM_EN
            acc        <= '0;
`endif
        end else begin
            state      <= state_next;
            addr       <= addr_next;
            loading    <= loading_next;
            frame_done <= done_next;
            err        <= err_next;
            wr.wr_en   <= do_write;
            if (do_write) begin
                wr.wr_addr <= addr;
                wr.wr_data <= DataWidth'(rx_byte);
            end
`ifdef IMG_LOADER_CHECKSUM_EN
            acc        <= acc_next;
`endif
        end
    end

    always_comb begin
        state_next   = state;
        addr_next    = addr;
        loading_next = loading;
        do_write     = 1'b0;
        done_next    = 1'b0;
        err_next     = ferr;
`ifdef IMG_LOADER_CHECKSUM_EN
        acc_next     = acc;
`endif
        case (state)
            ST_IDLE, ST_LOAD: begin
                if (byte_valid) begin
                    do_write = 1'b1;
`ifdef IMG_LOADER_CHECKSUM_EN
                    acc_next = acc ^ rx_byte;
`endif
                    if (addr == LAST_ADDR) begin
                        addr_next = '0;
`ifdef IMG_LOADER_CHECKSUM_EN
                        state_next   = ST_CHECK;
                        loading_next = 1'b1;
`else
                        state_next   = ST_IDLE;
                        loading_next = 1'b0;
                        done_next    = 1'b1;
`endif
                    end else begin
                        addr_next    = addr + AddressWidth'(1);
                        state_next   = ST_LOAD;
                        loading_next = 1'b1;
                    end
                end else if (state == ST_LOAD && timeout) begin
                    err_next     = 1'b1;
                    addr_next    = '0;
                    loading_next = 1'b0;
                    state_next   = ST_IDLE;
`ifdef IMG_LOADER_CHECKSUM_EN
                    acc_next     = '0;
`endif
                end
            end
`ifdef IMG_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (byte_valid || timeout) begin
                    done_next    = byte_valid && (rx_byte == acc);
                    err_next     = !(byte_valid && (rx_byte == acc));
                    loading_next = 1'b0;
                    addr_next    = '0;
                    state_next   = ST_IDLE;
                    acc_next     = '0;
                end
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

endmodule
